// File: rtl/dsp58_column_sequencer.sv
// dsp58_column_sequencer
// Sequences one vertical column of NUM_DSP cascaded DSP58 tiles: loads one B
// weight per tile, streams A rows with a one-cycle-per-stage systolic skew,
// drives per-tile OPMODE and flags the bottom-of-column cascade sum.
module dsp58_column_sequencer #(
   parameter int NUM_DSP  = 4,
   parameter int PIPE_LAT = 4,
   parameter int ROW_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_start,
   input  logic [ROW_W-1:0]       cfg_num_rows,
   input  logic                   b_in_valid,
   output logic                   b_in_ready,
   output logic [NUM_DSP-1:0]     b_wen,
   input  logic                   a_in_valid,
   output logic                   a_in_ready,
   output logic [NUM_DSP-1:0]     a_issue,
   output logic [9*NUM_DSP-1:0]   opmode,
   output logic                   y_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int BW = (NUM_DSP > 1) ? $clog2(NUM_DSP) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_B,
      STREAM,
      DRAIN
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ROW_W-1:0]     rows_left;
   logic [BW-1:0]        b_idx;
   logic [NUM_DSP-1:1]   sv_q;
   logic [NUM_DSP-1:0]   sv;
   logic [PIPE_LAT-1:0]  lat_q;
   logic                 b_hs;
   logic                 a_hs;
   logic                 pipe_empty;

   // sv[0] is the live issue event; higher stages are its registered delays
   assign sv         = {sv_q, a_hs};
   assign a_issue    = sv;
   assign y_valid    = lat_q[PIPE_LAT-1];
   assign pipe_empty = (sv_q == '0) && (lat_q == '0);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and handshake/strobe outputs
   always_comb begin
      state_nxt  = state;
      b_in_ready = 1'b0;
      a_in_ready = 1'b0;
      b_wen      = '0;
      busy       = 1'b0;
      done       = 1'b0;
      b_hs       = 1'b0;
      a_hs       = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            busy       = 1'b1;
            b_in_ready = 1'b1;
            b_hs       = b_in_valid;
            if (b_hs) begin
               b_wen = {{(NUM_DSP-1){1'b0}}, 1'b1} << b_idx;
               if (b_idx == BW'(NUM_DSP-1))
                  state_nxt = (rows_left == '0) ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            busy       = 1'b1;
            a_in_ready = (rows_left != '0);
            a_hs       = a_in_valid && a_in_ready;
            if (a_hs && (rows_left == ROW_W'(1))) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (pipe_empty) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job counters, skew shift register and output latency pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_left <= '0;
         b_idx     <= '0;
         sv_q      <= '0;
         lat_q     <= '0;
      end else begin
         if ((state == IDLE) && cfg_start) begin
            rows_left <= cfg_num_rows;
            b_idx     <= '0;
         end
         if (b_hs) b_idx <= b_idx + BW'(1);
         if (a_hs) rows_left <= rows_left - ROW_W'(1);
         for (int unsigned i = 1; i < NUM_DSP; i++) sv_q[i] <= sv[i-1];
         lat_q[0] <= sv[NUM_DSP-1];
         for (int unsigned k = 1; k < PIPE_LAT; k++) lat_q[k] <= lat_q[k-1];
      end
   end

   // Per-tile OPMODE: bottom tile multiplies only, upper tiles add PCIN
   always_comb begin
      opmode = '0;
      for (int unsigned i = 0; i < NUM_DSP; i++) begin
         if (sv[i]) opmode[9*i +: 9] = (i == 0) ? 9'h005 : 9'h015;
      end
   end

endmodule

// File: doc/dsp58_column_sequencer.md
Name: dsp58_column_sequencer

Overview:
- Sequences one vertical column of NUM_DSP cascaded DSP58 multiply tiles used by the GeMM DSP datapath.
- Loads one B weight per tile through one-hot b_wen strobes, then streams A rows through the column with a systolic one-cycle-per-stage skew.
- Generates per-tile OPMODE: tile 0 = multiply only; tiles above = multiply + PCIN.
- Flags when the bottom-of-column cascade sum is valid on y_data_out_fabric.

Parameters:
NUM_DSP, 4, number of cascaded DSP58 tiles in the column (2..16)
PIPE_LAT, 4, cycles from A presented at a tile to that tile's P valid (AREG+MREG+OPMODEREG/PREG path)
ROW_W, 16, width of the row-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  pulse; starts a job; ignored while busy=1
cfg_num_rows  in  ROW_W  A rows to stream this job; sampled on accepted cfg_start
b_in_valid  in  1  B weight word available from feeder
b_in_ready  out  1  sequencer accepts B word (LOAD_B only)
b_wen  out  NUM_DSP  one-hot CEB2 strobe; bit i loads B into tile i
a_in_valid  in  1  A row available from feeder
a_in_ready  out  1  sequencer accepts A row (STREAM only)
a_issue  out  NUM_DSP  per-tile CEA2 strobe; bit i = row entering tile i this cycle (skewed)
opmode  out  9*NUM_DSP  concatenated OPMODE, tile i at bits [9i+8:9i]
y_valid  out  1  bottom-tile cascade sum valid this cycle
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: FSM=IDLE. b_in_ready, b_wen, a_in_ready, a_issue, opmode, y_valid, busy, done all 0. Skew and latency shift registers and all counters cleared. Reset mid-job aborts immediately; no done pulse.
- FSM IDLE -> LOAD_B -> STREAM -> DRAIN -> IDLE.
- IDLE: on cfg_start, latch rows_left=cfg_num_rows, clear b_idx, go to LOAD_B. busy=1 from the next cycle.
- LOAD_B: b_in_ready=1. On handshake, b_wen = one-hot(b_idx) combinationally that same cycle and b_idx++. After the handshake with b_idx=NUM_DSP-1, go to STREAM. If rows_left=0, go to DRAIN instead. b_wen=0 outside handshake cycles.
- STREAM: a_in_ready = (rows_left!=0). An issue event is a_in_valid & a_in_ready; it decrements rows_left. On the issue with rows_left=1, go to DRAIN. Feeder bubbles are allowed.
- Skew: sv[0] = issue event. sv[i] = sv[i-1] delayed one cycle (registered shift). a_issue[i] = sv[i].
- OPMODE per tile i, combinational from sv[i]:
  - sv[i]=0 -> 9'h000 (P=0).
  - sv[i]=1, i=0 -> 9'h005 (X=M, Y=M, Z=0).
  - sv[i]=1, i>0 -> 9'h015 (X=M, Y=M, Z=PCIN).
  - A bubble therefore propagates consistently up the column.
- y_valid = sv[NUM_DSP-1] delayed PIPE_LAT cycles. Total issue->y_valid latency = NUM_DSP-1+PIPE_LAT cycles. Exactly one y_valid per issued row, in issue order.
- DRAIN: a_in_ready=0, b_in_ready=0. Stay until all sv bits and the latency pipe are empty, then pulse done for one cycle, set busy=0, return to IDLE. A cfg_start in the done cycle is ignored. A cfg_start is accepted from the following cycle.
- busy=1 in LOAD_B, STREAM, DRAIN.
- Simultaneous events:
  - cfg_start while busy: ignored; no latching.
  - b_in_valid outside LOAD_B: ignored.
  - a_in_valid outside STREAM: ignored.
  - The last A issue and the first DRAIN cycle may coincide with earlier rows' y_valid; no interaction.
- Counters: rows_left ROW_W bits, never wraps (decrement gated by !=0). b_idx is clog2(NUM_DSP) bits.

Test Plan:
- NUM_DSP=4, PIPE_LAT=4. cfg_start with rows=3, B words back-to-back, then A rows back-to-back from cycle t0 -> b_wen = 0001,0010,0100,1000 on consecutive cycles. opmode tile0=005 at t0..t0+2. Tile3=015 at t0+3..t0+5. y_valid at t0+7..t0+9. done at t0+10.
- Same job with a_in_valid deasserted one cycle between rows 1 and 2 -> opmode tile k shows 000 at the bubble cycle shifted by k. y_valid pattern is 1,0,1,1.
- rows=0 -> four b_wen strobes, no a_in_ready, no y_valid, done pulse after the last B load plus drain; busy returns to 0.
- b_in_valid stalls for 5 cycles mid-load -> b_wen holds 0 during the stall. b_idx resumes at the correct tile, and no tile is double-loaded.
- cfg_start pulsed during STREAM with rows=9 -> ignored; the original rows=3 job completes with exactly 3 y_valid.
- rst asserted 2 cycles after the first A issue -> next cycle all outputs 0, FSM IDLE, no done, no later y_valid. A new job afterwards behaves per scenario 1.
